refract_ray_seq: RTL and testbench

- Parametrised, sequential successor to the combinational refraction function in the raytracer.
- Takes one incident ray, a hit point, a unit surface normal and a refraction index ratio. Produces the refracted ray (Snell's law), or the reflected ray on total internal reflection, plus a 2-bit outcome code.
- Signed fixed-point throughout, with an iterative square-root unit, so the block closes timing at `WIDTH` = 32.
- Sits between the intersection stage and the ray queue, with valid/ready handshakes on both sides.

---
 rtl/refract_ray_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_refract_ray_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/refract_ray_seq.sv
`default_nettype none
// ============================================================================
// Module   : refract_ray_seq
// Brief    : Sequential Snell refraction / total-internal-reflection unit with
//            an iterative non-restoring square root and valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module refract_ray_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3*WIDTH-1:0]   in_dir,
  input  logic [3*WIDTH-1:0]   in_hit,
  input  logic [3*WIDTH-1:0]   in_normal,
  input  logic [WIDTH-1:0]     in_eta,
  input  logic [WIDTH-1:0]     in_eta_inv,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*WIDTH-1:0]   out_origin,
  output logic [3*WIDTH-1:0]   out_dir,
  output logic [1:0]           out_code,
  output logic [TAG_W-1:0]     out_tag
);

  // Internal arithmetic carries two guard bits above WIDTH.
  localparam int C_IW    = WIDTH + 2;
  // Cycles spent in SQRT; the leading root bit is resolved in K, so the root
  // has C_ITERS+1 bits and covers a radicand of C_IW bits (k up to ~2*ONE).
  localparam int C_ITERS = WIDTH / 2;
  localparam int C_R     = C_ITERS + 1;
  localparam int C_RW    = C_R + 3;
  localparam int C_CW    = $clog2(C_ITERS + 1);
  localparam logic signed [C_IW-1:0] C_ONE = {{(C_IW-1){1'b0}}, 1'b1} << FRAC;

  typedef enum logic [2:0] {S_IDLE, S_DOT, S_K, S_SQRT, S_COMB, S_OUT} state_t;

  state_t r_state, w_nxt;

  logic signed [C_IW-1:0]  r_d [3];
  logic signed [C_IW-1:0]  r_n [3];
  logic [3*WIDTH-1:0]      r_hit;
  logic [WIDTH-1:0]        r_eta_in, r_eta_inv;
  logic [TAG_W-1:0]        r_tag;
  logic signed [C_IW-1:0]  r_eta, r_c;
  logic                    r_exit;
  logic [1:0]              r_code;
  logic [C_IW-1:0]         r_a;
  logic signed [C_RW-1:0]  r_rem;
  logic [C_R-1:0]          r_q;
  logic [C_CW-1:0]         r_cnt;

  logic signed [C_IW-1:0]  w_dot, w_c2, w_e2, w_k, w_ec, w_coef, w_c2x;
  logic [C_IW-1:0]         w_rad;
  logic [1:0]              w_code;
  logic signed [C_RW-1:0]  w_rem_in, w_rem_sh, w_rem_nx;
  logic [C_R-1:0]          w_q_in, w_q_nx;
  logic [1:0]              w_pair;
  logic [3*WIDTH-1:0]      w_dir;

  // Fixed-point multiply: full product, arithmetic shift by FRAC, keep C_IW bits.
  function automatic logic signed [C_IW-1:0] mul(input logic signed [C_IW-1:0] a,
                                                 input logic signed [C_IW-1:0] b);
    logic signed [2*C_IW-1:0] p;
    p = $signed({{C_IW{a[C_IW-1]}}, a}) * $signed({{C_IW{b[C_IW-1]}}, b});
    return p[FRAC +: C_IW];
  endfunction

  function automatic logic signed [C_IW-1:0] sext(input logic [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  // Clamp a guarded value to the signed WIDTH range.
  function automatic logic [WIDTH-1:0] sat(input logic signed [C_IW-1:0] v);
    if ((&v[C_IW-1:WIDTH-1]) || !(|v[C_IW-1:WIDTH-1]))
      return v[WIDTH-1:0];
    else if (v[C_IW-1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_OUT);

  // Dot product, discriminant k, outcome code and the scaled sqrt radicand.
  always_comb begin
    w_dot = mul(r_n[0], r_d[0]) + mul(r_n[1], r_d[1]) + mul(r_n[2], r_d[2]);
    w_c2  = mul(r_c, r_c);
    w_e2  = mul(r_eta, r_eta);
    w_k   = C_ONE - mul(w_e2, C_ONE - w_c2);
    if (r_c == '0)
      w_code = 2'b11;
    else if (w_k < 0)
      w_code = 2'b10;
    else
      w_code = {1'b0, r_exit};
    if (|w_k[C_IW-1:C_IW-FRAC])
      w_rad = '1;
    else
      w_rad = {w_k[C_IW-FRAC-1:0], {FRAC{1'b0}}};
  end

  // One non-restoring square-root step; K seeds it from zero with the top pair.
  always_comb begin
    if (r_state == S_K) begin
      w_rem_in = '0;
      w_q_in   = '0;
      w_pair   = w_rad[C_IW-1 -: 2];
    end else begin
      w_rem_in = r_rem;
      w_q_in   = r_q;
      w_pair   = r_a[C_IW-1 -: 2];
    end
    w_rem_sh = (w_rem_in <<< 2) | $signed({{(C_RW-2){1'b0}}, w_pair});
    if (w_rem_in >= 0)
      w_rem_nx = w_rem_sh - $signed({1'b0, w_q_in, 2'b01});
    else
      w_rem_nx = w_rem_sh + $signed({1'b0, w_q_in, 2'b11});
    w_q_nx = {w_q_in[C_R-2:0], ~w_rem_nx[C_RW-1]};
  end

  // Output direction for refraction, reflection or pass-through.
  always_comb begin
    w_ec   = mul(r_eta, r_c);
    w_coef = w_ec - $signed({{(C_IW-C_R){1'b0}}, r_q});
    w_c2x  = r_c <<< 1;
    w_dir  = '0;
    for (int i = 0; i < 3; i++) begin
      case (r_code)
        2'b10:   w_dir[i*WIDTH +: WIDTH] = sat(r_d[i] + mul(w_c2x, r_n[i]));
        2'b11:   w_dir[i*WIDTH +: WIDTH] = sat(r_d[i]);
        default: w_dir[i*WIDTH +: WIDTH] = sat(mul(r_eta, r_d[i]) + mul(w_coef, r_n[i]));
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // Next-state sequencing.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_nxt = S_DOT;
      S_DOT:  w_nxt = S_K;
      S_K:    w_nxt = w_code[1] ? S_COMB : S_SQRT;
      S_SQRT: if (r_cnt == C_CW'(C_ITERS - 1)) w_nxt = S_COMB;
      S_COMB: w_nxt = S_OUT;
      S_OUT:  if (out_ready) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_d[i] <= '0;
        r_n[i] <= '0;
      end
      r_hit      <= '0;
      r_eta_in   <= '0;
      r_eta_inv  <= '0;
      r_tag      <= '0;
      r_eta      <= '0;
      r_c        <= '0;
      r_exit     <= 1'b0;
      r_code     <= '0;
      r_a        <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      out_origin <= '0;
      out_dir    <= '0;
      out_code   <= '0;
      out_tag    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          for (int i = 0; i < 3; i++) begin
            r_d[i] <= sext(in_dir[i*WIDTH +: WIDTH]);
            r_n[i] <= sext(in_normal[i*WIDTH +: WIDTH]);
          end
          r_hit     <= in_hit;
          r_eta_in  <= in_eta;
          r_eta_inv <= in_eta_inv;
          r_tag     <= in_tag;
        end
        S_DOT: begin
          // A positive dot product means the ray leaves the surface.
          if (w_dot > 0) begin
            for (int i = 0; i < 3; i++) r_n[i] <= -r_n[i];
            r_c    <= w_dot;
            r_eta  <= sext(r_eta_inv);
            r_exit <= 1'b1;
          end else begin
            r_c    <= -w_dot;
            r_eta  <= sext(r_eta_in);
            r_exit <= 1'b0;
          end
        end
        S_K: begin
          r_code <= w_code;
          r_a    <= w_rad << 2;
          r_rem  <= w_rem_nx;
          r_q    <= w_q_nx;
          r_cnt  <= '0;
        end
        S_SQRT: begin
          r_a   <= r_a << 2;
          r_rem <= w_rem_nx;
          r_q   <= w_q_nx;
          r_cnt <= r_cnt + 1'b1;
        end
        S_COMB: begin
          out_origin <= r_hit;
          out_dir    <= w_dir;
          out_code   <= r_code;
          out_tag    <= r_tag;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_refract_ray_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_refract_ray_seq
// Brief    : Directed self-checking bench for refract_ray_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_refract_ray_seq;
  localparam int W  = 32;
  localparam int F  = 16;
  localparam int TW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3*W-1:0]  in_dir = '0, in_hit = '0, in_normal = '0;
  logic [W-1:0]    in_eta = '0, in_eta_inv = '0;
  logic [TW-1:0]   in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [3*W-1:0]  out_origin, out_dir;
  logic [1:0]      out_code;
  logic [TW-1:0]   out_tag;

  int n_checks = 0;
  int n_pass   = 0;

  refract_ray_seq #(.WIDTH(W), .FRAC(F), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dir(in_dir), .in_hit(in_hit), .in_normal(in_normal),
    .in_eta(in_eta), .in_eta_inv(in_eta_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_origin(out_origin), .out_dir(out_dir),
    .out_code(out_code), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
    longint diff;
    n_checks++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
  endtask

  function automatic longint comp(input logic [3*W-1:0] v, input int i);
    return longint'($signed(v[i*W +: W]));
  endfunction

  // Wait for in_ready, present one request and hold it for exactly the accept edge.
  task automatic accept(input int dx, input int dy, input int dz,
                        input int nx, input int ny, input int nz,
                        input int eta, input int eta_inv,
                        input logic [3*W-1:0] hit, input logic [TW-1:0] tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_dir     = {dz, dy, dx};
    in_normal  = {nz, ny, nx};
    in_eta     = eta;
    in_eta_inv = eta_inv;
    in_hit     = hit;
    in_tag     = tag;
    in_valid   = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_valid_drop"}, longint'(out_valid), 0, 0);
    check({tag, "_ready_back"}, longint'(in_ready), 1, 0);
  endtask

  initial begin
    int lat;
    int stable;
    int seen;
    logic [3*W-1:0] snap_dir;
    logic [TW-1:0]  snap_tag;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(out_valid), 0, 0);
    check("rst_out_dir_z", comp(out_dir, 2), 0, 0);
    check("rst_out_tag", longint'(out_tag), 0, 0);
    check("rst_out_code", longint'(out_code), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 1, 0);

    // Entering refraction along the normal: T = -ONE on z.
    accept(0, 0, -'h10000, 0, 0, 'h10000, 'h8000, 'h10000,
           {32'h0003_0000, 32'hFFFE_0000, 32'h0001_8000}, 8'hA1);
    wait_result(lat);
    check("t1_latency", lat, 19, 0);
    check("t1_code", longint'(out_code), 0, 0);
    check("t1_dir_x", comp(out_dir, 0), 0, 0);
    check("t1_dir_y", comp(out_dir, 1), 0, 0);
    check("t1_dir_z", comp(out_dir, 2), -'h10000, 0);
    check("t1_origin_x", comp(out_origin, 0), 'h18000, 0);
    check("t1_origin_y", comp(out_origin, 1), -'h20000, 0);
    check("t1_tag", longint'(out_tag), 'hA1, 0);
    handshake("t1");

    // Exiting: normal flipped, eta_inv used, T = +ONE on z.
    accept(0, 0, 'h10000, 0, 0, 'h10000, 'h8000, 'h18000, '0, 8'hB2);
    wait_result(lat);
    check("t2_latency", lat, 19, 0);
    check("t2_code", longint'(out_code), 1, 0);
    check("t2_dir_x", comp(out_dir, 0), 0, 2);
    check("t2_dir_z", comp(out_dir, 2), 'h10000, 2);
    handshake("t2");

    // Total internal reflection at 45 degrees going out of a denser medium.
    accept('hB505, 0, 'hB505, 0, 0, 'h10000, 'h8000, 'h18000, '0, 8'hC3);
    wait_result(lat);
    check("t3_latency", lat, 3, 0);
    check("t3_code", longint'(out_code), 2, 0);
    check("t3_dir_x", comp(out_dir, 0), 'hB505, 2);
    check("t3_dir_z", comp(out_dir, 2), -'hB505, 2);
    handshake("t3");

    // Grazing: direction passes through unchanged.
    accept('h10000, 0, 0, 0, 0, 'h10000, 'h8000, 'h10000, '0, 8'hD4);
    wait_result(lat);
    check("t4_latency", lat, 3, 0);
    check("t4_code", longint'(out_code), 3, 0);
    check("t4_dir_x", comp(out_dir, 0), 'h10000, 0);
    check("t4_dir_z", comp(out_dir, 2), 0, 0);
    handshake("t4");

    // Backpressure: result held, second request refused while busy.
    accept(0, 'h10000, 0, 0, 0, 'h10000, 'h8000, 'h10000, '0, 8'h5C);
    wait_result(lat);
    check("bp_latency", lat, 3, 0);
    snap_dir = out_dir;
    snap_tag = out_tag;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_tag   = 8'h77;
      in_dir   = {32'h0, 32'h0, 32'h0001_0000};
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || out_dir !== snap_dir || out_tag !== snap_tag) stable = 0;
    end
    check("bp_stable", stable, 1, 0);
    check("bp_dir_y", comp(out_dir, 1), 'h10000, 0);
    check("bp_tag", longint'(out_tag), 'h5C, 0);
    @(negedge clk);
    in_valid = 1'b0;
    handshake("bp");
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("bp_no_second", seen, 0, 0);

    // Reset in the middle of the square root.
    accept(0, 0, -'h10000, 0, 0, 'h10000, 'h8000, 'h10000, '1, 8'hEE);
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0, 0);
    check("mid_rst_dir_y", comp(out_dir, 1), 0, 0);
    check("mid_rst_tag", longint'(out_tag), 0, 0);
    check("mid_rst_code", longint'(out_code), 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", longint'(in_ready), 1, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("mid_rst_no_stale", seen, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
